vpu_issue_queue: RTL

Receives vector instructions and their scalar operands from the CPU, buffers them in an in-order FIFO, and issues them to the VPU decode stage over a valid/ready handshake. It is the CPU→VPU counterpart of the VPU commit stage. It tracks how many issued instructions still await commit, throttles issue at a configurable limit, and reports a busy status so the CPU can fence on vector completion.

---
 rtl/vpu_pkg.sv | 10 +
 rtl/vpu_sync_fifo.sv | 39 +++
 rtl/vpu_issue_queue.sv | 75 +++++++
 3 files changed

// File: rtl/vpu_pkg.sv
// vpu_pkg: issue-queue entry layout and default sizing shared by the VPU front end.
package vpu_pkg;
  localparam int VPU_IQ_DEPTH = 4;
  localparam int VPU_IQ_MAX_OUTSTANDING = 8;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } vpu_issue_entry_t;
endpackage

// File: rtl/vpu_sync_fifo.sv
// vpu_sync_fifo: single-clock FIFO with combinational head read and occupancy count.
module vpu_sync_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic wr, rd;
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign wr    = push && (!full || pop);
  assign rd    = pop && !empty;
  assign rdata = mem[rptr];
  // storage is cleared so the head reads zero out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr) mem[wptr] <= wdata;
      wptr  <= wr ? wptr + AW'(1) : wptr;
      rptr  <= rd ? rptr + AW'(1) : rptr;
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
endmodule

// File: rtl/vpu_issue_queue.sv
// vpu_issue_queue: CPU->VPU in-order issue buffer with outstanding-credit throttle.
// Define VPU_ISSUE_BYPASS_EN to let a push into an empty queue issue in the same cycle.
module vpu_issue_queue
  import vpu_pkg::*;
#(
  parameter int DEPTH = VPU_IQ_DEPTH,
  parameter int MAX_OUTSTANDING = VPU_IQ_MAX_OUTSTANDING
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        vector_instr_valid_i,
  input  logic [31:0] vector_instr_i,
  input  logic [31:0] vector_rs1_i,
  input  logic [31:0] vector_rs2_i,
  output logic        vector_instr_ready_o,
  output logic        issue_valid_o,
  output logic [31:0] issue_instr_o,
  output logic [31:0] issue_rs1_o,
  output logic [31:0] issue_rs2_o,
  input  logic        issue_ready_i,
  input  logic        commit_i,
  output logic        vpu_busy_o,
  output logic        commit_err_o
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [OW-1:0] OMAX = OW'(MAX_OUTSTANDING);
  vpu_issue_entry_t in_entry, head, out_entry;
  logic [OW-1:0] outstanding;
  logic [AW:0] count;
  logic full, empty, push_acc, gate_open, byp, pop_fire, fifo_push, fifo_pop;
  assign in_entry = '{instr: vector_instr_i, rs1: vector_rs1_i, rs2: vector_rs2_i};
  assign vector_instr_ready_o = !full;
  assign push_acc  = vector_instr_valid_i && !full;
  assign gate_open = outstanding != OMAX;
`ifdef VPU_ISSUE_BYPASS_EN
  assign byp = empty && push_acc && gate_open;
`else
  assign byp = 1'b0;
`endif
  assign issue_valid_o = (!empty && gate_open) || byp;
  assign out_entry     = byp ? in_entry : head;
  assign issue_instr_o = out_entry.instr;
  assign issue_rs1_o   = out_entry.rs1;
  assign issue_rs2_o   = out_entry.rs2;
  assign pop_fire  = issue_valid_o && issue_ready_i;
  // a bypassed entry that is taken immediately never touches storage
  assign fifo_push = push_acc && !(byp && issue_ready_i);
  assign fifo_pop  = pop_fire && !byp;
  assign vpu_busy_o = (count != '0) || (outstanding != '0);

  vpu_sync_fifo #(.WIDTH($bits(vpu_issue_entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_i),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (in_entry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      outstanding  <= '0;
      commit_err_o <= 1'b0;
    end else if (pop_fire && !commit_i) begin
      outstanding <= outstanding + OW'(1);
    end else if (!pop_fire && commit_i) begin
      outstanding  <= outstanding == '0 ? outstanding : outstanding - OW'(1);
      commit_err_o <= commit_err_o || outstanding == '0;
    end
  end
endmodule
